// File: rtl/palette_pkg.sv
// Shared types and default colours for the sprite palette decoder.
// Colours are packed {B,G,R}, matching the VGA pixel mux.
package palette_pkg;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

    typedef enum logic {INIT, RUN} state_t;

    localparam int NUM_DEFAULT = 6;

    localparam rgb_t FONDO    = 24'h34904a;
    localparam rgb_t NEGRO    = 24'h000000;
    localparam rgb_t AMARILLO = 24'h1cd5ee;
    localparam rgb_t ROJO     = 24'h0000ff;
    localparam rgb_t BLANCO   = 24'hffffff;
    localparam rgb_t CAFE     = 24'h012871;

    localparam rgb_t DEFAULT_PALETTE [NUM_DEFAULT] = '{FONDO, NEGRO, AMARILLO, ROJO, BLANCO, CAFE};

    // Entries beyond the named sprite colours default to black.
    function automatic rgb_t default_color(input int unsigned idx);
        rgb_t c;
        c = '0;
        for (int i = 0; i < NUM_DEFAULT; i++) begin
            if (idx == int'(i)) c = DEFAULT_PALETTE[i];
        end
        return c;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Frame counter that toggles the blink phase every BLINK_FRAMES frame starts.
module blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    output logic blink_phase
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (count == LAST) begin
                count       <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/palette_lut.sv
// Run-time programmable palette decoder: (palette, index) -> 24-bit pixel in 2 stages.
// After reset the table is self-loaded with the default sprite colours, one entry per cycle.
module palette_lut
    import palette_pkg::*;
#(
    parameter int          NUM_PALETTES = 4,
    parameter int          NUM_COLORS   = 8,
    parameter int          TRANSP_IDX   = 0,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [23:0] BLINK_RGB    = 24'hffffff,
    parameter int          PAL_W        = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1,
    parameter int          IDX_W        = $clog2(NUM_COLORS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic [PAL_W-1:0] pix_pal,
    input  logic [IDX_W-1:0] pix_idx,
    output logic             out_valid,
    output logic [23:0]      out_rgb,
    output logic             out_transp,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [PAL_W-1:0] wr_pal,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [23:0]      wr_rgb,
    input  logic             wr_blink,
    input  logic             blink_en,
    output logic             init_done
);

    localparam logic [PAL_W-1:0] LAST_PAL = PAL_W'(NUM_PALETTES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COLORS - 1);

    rgb_t   table_rgb   [NUM_PALETTES][NUM_COLORS];
    logic   table_blink [NUM_PALETTES][NUM_COLORS];

    state_t           state;
    logic [PAL_W-1:0] init_pal;
    logic [IDX_W-1:0] init_idx;

    logic             blink_phase;
    logic             pix_hit;
    logic             wr_hit;
    rgb_t             rd_rgb;
    logic             rd_blink;

    logic             s1_valid;
    rgb_t             s1_rgb;
    logic             s1_transp;
    logic             s1_blink;

    blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink_timer (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .blink_phase(blink_phase)
    );

    // INIT walks the table palette-major; the init pointer is kept split into palette and entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            init_pal  <= '0;
            init_idx  <= '0;
            init_done <= 1'b0;
            wr_ready  <= 1'b0;
        end else if (state == INIT) begin
            if (init_idx == LAST_IDX) begin
                init_idx <= '0;
                if (init_pal == LAST_PAL) begin
                    state     <= RUN;
                    init_done <= 1'b1;
                    wr_ready  <= 1'b1;
                end else begin
                    init_pal <= init_pal + 1'b1;
                end
            end else begin
                init_idx <= init_idx + 1'b1;
            end
        end
    end

    assign wr_hit  = wr_valid && wr_ready && (32'(wr_pal) < NUM_PALETTES) && (32'(wr_idx) < NUM_COLORS);
    assign pix_hit = pix_valid && (state == RUN) && (32'(pix_pal) < NUM_PALETTES) && (32'(pix_idx) < NUM_COLORS);

    // Table storage has no reset; INIT owns the write port until every entry is reloaded.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            table_rgb[init_pal][init_idx]   <= default_color(32'(init_idx));
            table_blink[init_pal][init_idx] <= 1'b0;
        end else if (wr_hit) begin
            table_rgb[wr_pal][wr_idx]   <= wr_rgb;
            table_blink[wr_pal][wr_idx] <= wr_blink;
        end
    end

    assign rd_rgb   = table_rgb[pix_pal][pix_idx];
    assign rd_blink = table_blink[pix_pal][pix_idx];

    // Stage 1: the asynchronous read sees the pre-write value, giving read-before-write on collisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_rgb    <= '0;
            s1_transp <= 1'b0;
            s1_blink  <= 1'b0;
        end else begin
            s1_valid  <= pix_valid;
            s1_rgb    <= pix_hit ? rd_rgb : '0;
            s1_transp <= pix_hit && (pix_idx == IDX_W'(TRANSP_IDX));
            s1_blink  <= pix_hit && rd_blink;
        end
    end

    // Stage 2: blink substitution; stage-1 data is already zero for idle or missed lookups.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_rgb    <= '0;
            out_transp <= 1'b0;
        end else begin
            out_valid  <= s1_valid;
            out_rgb    <= (blink_en && blink_phase && s1_blink) ? BLINK_RGB : s1_rgb;
            out_transp <= s1_transp;
        end
    end

endmodule
